swd_xfer_retry: RTL
===================

SWD_XFER_RETRY -- requirements
Module: swd_xfer_retry

Interface
REQ-001 SHALL have parameter RETRY_W, default 16, giving the width of the retry limit and retry counter.
REQ-002 SHALL have clocking fixed as: one clock; reset is synchronous and active-high.
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port req_valid, input, 1, a transfer request is presented.
REQ-006 SHALL have port req_ready, output, 1, the block accepts the request.
REQ-007 SHALL have ports req_addr32 (input, 2, A[3:2]), req_rnw (input, 1, 1 means read), req_apndp (input, 1, 1 means AP), and req_wdata (input, 32, write data).
REQ-008 SHALL have port wait_limit, input, RETRY_W, the maximum number of reissues after a WAIT ack.
REQ-009 SHALL have port abort, input, 1, a level that cancels further retries.
REQ-010 SHALL have ports rsp_valid (output, 1), rsp_ready (input, 1), rsp_ack (output, 3), rsp_rdata (output, 32), rsp_perr (output, 1), and rsp_retries (output, RETRY_W, number of reissues performed).
REQ-011 SHALL have link-side outputs if_go (1), if_addr32 (2), if_rnw (1), if_apndp (1), and if_dwrite (32), all driven to the SWD link engine.
REQ-012 SHALL have link-side inputs if_idle (1), if_ack (3), if_dread (32), and if_perr (1), all driven from the SWD link engine.

Function
REQ-013 SHALL use the states IDLE, LAUNCH, BUSY, EVAL and RESP.
REQ-014 SHALL drive req_ready = 1 only in IDLE; on req_valid&req_ready it SHALL latch addr32, rnw, apndp and wdata, clear the retry counter, and go to LAUNCH.
REQ-015 SHALL drive if_addr32, if_rnw, if_apndp and if_dwrite from the latched registers only, so they stay stable for the whole transfer, including retries.
REQ-016 In LAUNCH, SHALL assert if_go = 1 and hold it until if_idle is sampled 0, because the link engine samples go only on its rising-edge ticks; it SHALL then deassert if_go and go to BUSY.
REQ-017 In BUSY, SHALL wait for if_idle = 1, then go to EVAL.
REQ-018 In EVAL, SHALL take one cycle and branch on if_ack:
- 3'b001 (OK) -> RESP;
- 3'b010 (WAIT), counter < wait_limit, abort = 0 -> counter + 1, then LAUNCH;
- 3'b010 with the counter equal to wait_limit, or with abort = 1 -> RESP with ack 3'b010;
- any other value (FAULT 3'b100, no-response 3'b111, or garbage) -> RESP with no retry.
REQ-019 On entering RESP, SHALL latch rsp_ack = if_ack and rsp_retries = the counter.
- rsp_rdata = if_dread if rnw & ack OK, else 0.
- rsp_perr = if_perr if rnw & ack OK, else 0.
REQ-020 In RESP, SHALL hold rsp_valid = 1 and all rsp_* fields stable until rsp_ready = 1 is sampled, then return to IDLE; req_ready SHALL stay 0 in that cycle.
REQ-021 SHALL treat wait_limit = 0 as no retries: the first WAIT is reported with rsp_retries = 0.
REQ-022 SHALL sample abort only in EVAL; a transfer already in flight on the link SHALL always run to completion.
REQ-023 SHALL saturate the retry counter at wait_limit, never wrapping.
REQ-024 SHALL ignore a change in wait_limit during a transfer until the next EVAL comparison.
REQ-025 SHALL have a latency from acceptance to if_go = 1 of exactly 1 cycle.

Reset
REQ-026 On rst = 1 in any state, SHALL enter IDLE at the next clock edge and set if_go = 0, rsp_valid = 0, rsp_ack = 0, rsp_rdata = 0, rsp_perr = 0, rsp_retries = 0, and the latched request and counter to 0.
REQ-027 SHALL set req_ready = 1 in the first cycle after rst deasserts.
REQ-028 A reset that arrives during BUSY SHALL discard the transfer with no response; the link engine shares rst and so also returns to idle.

Verification
REQ-029 Read OK: a request with addr32 = 2'b01, rnw = 1, apndp = 0 on a link model that returns ack 001 and dread 0x2BA01477 -> one response with ack 001, rdata 0x2BA01477, perr 0, retries 0.
REQ-030 WAIT retry: wait_limit = 3 and a link model that returns WAIT twice then OK on a write of 0x50000000 -> if_go pulses 3 times, if_dwrite is constant, the response has ack 001 and retries 2.
REQ-031 WAIT exhaustion: wait_limit = 2 and a link model that always returns WAIT -> exactly 3 link transfers, the response has ack 010 and retries 2; with wait_limit = 0 -> 1 transfer and retries 0.
REQ-032 FAULT and parity error:
- ack 100 -> no retry, the response has ack 100 and rdata 0;
- a read with ack 001 and if_perr = 1 -> rsp_perr = 1.
REQ-033 Abort and backpressure:
- abort raised during the 2nd WAIT transfer -> the response follows that transfer with ack 010 and retries 1;
- rsp_ready held 0 for 10 cycles -> rsp_* are stable and req_ready = 0 throughout.
REQ-034 Reset mid-transfer: rst asserted in BUSY -> the next cycle has if_go = 0, rsp_valid = 0 and req_ready = 1 after release; no stale response afterwards.

Source files
------------

// File: rtl/swd_xfer_retry.sv
// SWD transfer sequencer: issues one DP/AP access to the link engine, reissues it
// on WAIT up to a programmable limit, and returns a single response record.
module swd_xfer_retry #(
   parameter int unsigned RETRY_W = 16
) (
   input  logic               clk,
   input  logic               rst,

   input  logic               req_valid,
   output logic               req_ready,
   input  logic [1:0]         req_addr32,
   input  logic               req_rnw,
   input  logic               req_apndp,
   input  logic [31:0]        req_wdata,

   input  logic [RETRY_W-1:0] wait_limit,
   input  logic               abort,

   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [2:0]         rsp_ack,
   output logic [31:0]        rsp_rdata,
   output logic               rsp_perr,
   output logic [RETRY_W-1:0] rsp_retries,

   output logic               if_go,
   output logic [1:0]         if_addr32,
   output logic               if_rnw,
   output logic               if_apndp,
   output logic [31:0]        if_dwrite,

   input  logic               if_idle,
   input  logic [2:0]         if_ack,
   input  logic [31:0]        if_dread,
   input  logic               if_perr
);

   localparam logic [2:0] ACK_OK   = 3'b001;
   localparam logic [2:0] ACK_WAIT = 3'b010;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LAUNCH = 3'd1,
      BUSY   = 3'd2,
      EVAL   = 3'd3,
      RESP   = 3'd4
   } state_e;

   state_e               state_q,       state_d;
   logic [1:0]           addr32_q,      addr32_d;
   logic                 rnw_q,         rnw_d;
   logic                 apndp_q,       apndp_d;
   logic [31:0]          wdata_q,       wdata_d;
   logic [RETRY_W-1:0]   cnt_q,         cnt_d;
   logic                 go_q,          go_d;
   logic                 rsp_valid_q,   rsp_valid_d;
   logic [2:0]           rsp_ack_q,     rsp_ack_d;
   logic [31:0]          rsp_rdata_q,   rsp_rdata_d;
   logic                 rsp_perr_q,    rsp_perr_d;
   logic [RETRY_W-1:0]   rsp_retries_q, rsp_retries_d;

   logic                 ack_ok;
   logic                 do_retry;

   assign ack_ok   = (if_ack == ACK_OK);
   // The counter can only reach wait_limit, so the increment below never wraps.
   assign do_retry = (if_ack == ACK_WAIT) && (cnt_q < wait_limit) && !abort;

   always_comb begin
      // NOTE: every _d starts as its _q so no branch leaves one unassigned (no latches).
      state_d       = state_q;
      addr32_d      = addr32_q;
      rnw_d         = rnw_q;
      apndp_d       = apndp_q;
      wdata_d       = wdata_q;
      cnt_d         = cnt_q;
      go_d          = go_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_ack_d     = rsp_ack_q;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_perr_d    = rsp_perr_q;
      rsp_retries_d = rsp_retries_q;

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               addr32_d = req_addr32;
               rnw_d    = req_rnw;
               apndp_d  = req_apndp;
               wdata_d  = req_wdata;
               cnt_d    = '0;
               go_d     = 1'b1;
               state_d  = LAUNCH;
            end
         end

         // go is held until the engine shows it has picked the transfer up.
         LAUNCH: begin
            if (!if_idle) begin
               go_d    = 1'b0;
               state_d = BUSY;
            end
         end

         BUSY: begin
            if (if_idle) begin
               state_d = EVAL;
            end
         end

         EVAL: begin
            if (do_retry) begin
               cnt_d   = cnt_q + RETRY_W'(1);
               go_d    = 1'b1;
               state_d = LAUNCH;
            end else begin
               rsp_valid_d   = 1'b1;
               rsp_ack_d     = if_ack;
               rsp_retries_d = cnt_q;
               rsp_rdata_d   = (rnw_q && ack_ok) ? if_dread : '0;
               rsp_perr_d    = rnw_q && ack_ok && if_perr;
               state_d       = RESP;
            end
         end

         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         state_q       <= IDLE;
         addr32_q      <= '0;
         rnw_q         <= 1'b0;
         apndp_q       <= 1'b0;
         wdata_q       <= '0;
         cnt_q         <= '0;
         go_q          <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_ack_q     <= '0;
         rsp_rdata_q   <= '0;
         rsp_perr_q    <= 1'b0;
         rsp_retries_q <= '0;
      end else begin
         state_q       <= state_d;
         addr32_q      <= addr32_d;
         rnw_q         <= rnw_d;
         apndp_q       <= apndp_d;
         wdata_q       <= wdata_d;
         cnt_q         <= cnt_d;
         go_q          <= go_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_ack_q     <= rsp_ack_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_perr_q    <= rsp_perr_d;
         rsp_retries_q <= rsp_retries_d;
      end
   end

   assign req_ready   = (state_q == IDLE);

   assign if_go       = go_q;
   assign if_addr32   = addr32_q;
   assign if_rnw      = rnw_q;
   assign if_apndp    = apndp_q;
   assign if_dwrite   = wdata_q;

   assign rsp_valid   = rsp_valid_q;
   assign rsp_ack     = rsp_ack_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_perr    = rsp_perr_q;
   assign rsp_retries = rsp_retries_q;

endmodule
